// File: rtl/dac_spi_sequencer.sv
// Multi-channel serial DAC update engine.
// Snapshots NUM_CH samples, shifts each out as a 16-bit MCP49x2-style frame over a
// shared SCLK/SDI bus (one chip select per two-channel device), pulses LDAC, then
// strobes sample_tick to advance the upstream wave generators.
module dac_spi_sequencer #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned LDAC_W  = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       run,
  input  logic [15:0]                period,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic [NUM_CH-1:0]          ch_buf,
  input  logic [NUM_CH-1:0]          ch_gain2x,
  input  logic [NUM_CH-1:0]          ch_shdn_n,
  output logic [(NUM_CH+1)/2-1:0]    cs_n,
  output logic                       sclk,
  output logic                       sdi,
  output logic                       ldac_n,
  output logic                       sample_tick,
  output logic                       busy,
  output logic [7:0]                 overrun_cnt
);

  localparam int unsigned ND   = (NUM_CH + 1) / 2;
  localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ChW-1:0] ChLast   = ChW'(NUM_CH - 1);
  localparam logic [15:0]    DivLast  = 16'(CLK_DIV - 1);
  localparam logic [15:0]    LdacLast = 16'(LDAC_W - 1);

  // The LOAD step is the IDLE cycle in which a start is accepted: the snapshot is
  // captured on that edge so the first frame's chip select is low on the very next cycle.
  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StCsHold,
    StGap,
    StLdac,
    StTick
  } state_e;

  state_e         state_q;
  logic [15:0]    per_cnt_q;
  logic [15:0]    tmr_q;
  logic [3:0]     bit_q;
  logic [ChW-1:0] ch_q;
  logic [ChW-1:0] ch_nxt;
  logic [15:0]    frame_q [NUM_CH];
  logic [15:0]    frame_d [NUM_CH];
  logic           start_req;

  // Build the command frame for every channel from the live inputs.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      frame_d[c] = {1'(c % 2), ch_buf[c], ~ch_gain2x[c], ch_shdn_n[c],
                    12'(ch_data[c*DATA_W +: DATA_W]) << (12 - DATA_W)};
    end
  end

  assign ch_nxt    = ch_q + ChW'(1);
  // period=0 requests on every IDLE cycle, so back-to-back running never overruns.
  assign start_req = run && ((period == 16'd0) ? (state_q == StIdle) : (per_cnt_q == 16'd0));

  // Free-running update period counter, parked at zero while stopped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt_q <= '0;
    end else if (!run || period == 16'd0) begin
      per_cnt_q <= '0;
    end else if (per_cnt_q == period - 16'd1) begin
      per_cnt_q <= '0;
    end else begin
      per_cnt_q <= per_cnt_q + 16'd1;
    end
  end

  // Sequencer FSM; all bus outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      tmr_q       <= '0;
      bit_q       <= 4'd15;
      ch_q        <= '0;
      frame_q     <= '{default: '0};
      cs_n        <= '1;
      sclk        <= 1'b0;
      sdi         <= 1'b0;
      ldac_n      <= 1'b1;
      sample_tick <= 1'b0;
      busy        <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      sample_tick <= 1'b0;
      if (start_req && state_q != StIdle && overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (start_req) begin
            frame_q <= frame_d;
            state_q <= StShift;
            ch_q    <= '0;
            bit_q   <= 4'd15;
            tmr_q   <= '0;
            cs_n    <= ~ND'(1);
            sclk    <= 1'b0;
            sdi     <= frame_d[0][15];
            busy    <= 1'b1;
          end
        end
        StShift: begin
          if (tmr_q == DivLast) begin
            tmr_q <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_q == 4'd0) begin
                state_q <= StCsHold;
              end else begin
                bit_q <= bit_q - 4'd1;
                sdi   <= frame_q[ch_q][bit_q - 4'd1];
              end
            end
          end else begin
            tmr_q <= tmr_q + 16'd1;
          end
        end
        StCsHold: begin
          if (tmr_q == DivLast) begin
            tmr_q   <= '0;
            state_q <= StGap;
            cs_n    <= '1;
            sdi     <= 1'b0;
          end else begin
            tmr_q <= tmr_q + 16'd1;
          end
        end
        StGap: begin
          if (tmr_q == DivLast) begin
            tmr_q <= '0;
            if (ch_q == ChLast) begin
              state_q <= StLdac;
              ldac_n  <= 1'b0;
            end else begin
              state_q <= StShift;
              ch_q    <= ch_nxt;
              bit_q   <= 4'd15;
              cs_n    <= ~(ND'(1) << (ch_nxt >> 1));
              sdi     <= frame_q[ch_nxt][15];
            end
          end else begin
            tmr_q <= tmr_q + 16'd1;
          end
        end
        StLdac: begin
          if (tmr_q == LdacLast) begin
            tmr_q       <= '0;
            state_q     <= StTick;
            ldac_n      <= 1'b1;
            sample_tick <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 16'd1;
          end
        end
        StTick: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/dac_spi_sequencer.md
# dac_spi_sequencer

Parametrised multi-channel serial DAC update engine for the waveform generator datapath. It replaces the fixed dual-channel DAC driver and the top-level LDAC falling-edge detector. It snapshots NUM_CH sample words, shifts each out as a 16-bit MCP49x2-style command frame over a shared SCLK/SDI bus with one chip-select per two-channel device, pulses LDAC to update all outputs together, and then issues the `sample_tick` that advances the upstream wave generators. Programmable update period, per-channel gain/buffer/shutdown bits and overrun counting are new relative to the previous driver.

## Interface
- NUM_CH, 2, channel count, 1..8; device count ND = (NUM_CH+1)/2
- DATA_W, 12, sample width, 8..12; left-justified into the 12-bit field, LSBs zero-padded
- CLK_DIV, 4, clk cycles per SCLK half-period, ≥2
- LDAC_W, 2, ldac_n low width in clk cycles, ≥1

- clk  in  1  system clock (CLK100 domain)
- reset_n  in  1  asynchronous active-low reset
- run  in  1  enable periodic updates
- period  in  16  clk cycles between update starts; 0 = back-to-back
- ch_data  in  NUM_CH*DATA_W  unsigned samples, channel c at [c*DATA_W +: DATA_W]
- ch_buf  in  NUM_CH  VREF buffer bit per channel
- ch_gain2x  in  NUM_CH  1 = 2x gain (GA_n=0)
- ch_shdn_n  in  NUM_CH  0 = shut channel down
- cs_n  out  ND  device chip selects, active low
- sclk  out  1  serial clock, idle low
- sdi  out  1  serial data, MSB first
- ldac_n  out  1  latch DAC outputs, active low
- sample_tick  out  1  one-cycle strobe at update end
- busy  out  1  update in progress
- overrun_cnt  out  8  saturating count of skipped starts

## Operation
- Frame for channel c: {c[0], ch_buf[c], ~ch_gain2x[c], ch_shdn_n[c], data12}. data12 = ch_data[c] << (12-DATA_W). The frame is sent on cs_n[c>>1].
- FSM states: IDLE → LOAD → SHIFT → CS_HOLD → GAP → (next channel: SHIFT | last: LDAC) → TICK → IDLE.
- Period counter: held at 0 while run=0. While run=1 it counts 0..period-1 and wraps.
  - A start request fires when the count is 0.
  - period=0 means a start request on every IDLE cycle.
- Start request while busy: the request is dropped and overrun_cnt increments, saturating at 255.
- LOAD (cycle S): all ch_* inputs are snapshotted. Later input changes do not affect the current update.
- SHIFT: 16 bits per frame, each 2*CLK_DIV cycles: CLK_DIV with sclk low, then CLK_DIV with sclk high. sdi changes only while sclk is low, at bit start.
- CS_HOLD: sclk low, cs_n still low, for CLK_DIV cycles.
- GAP: all cs_n high for CLK_DIV cycles.
- LDAC: ldac_n low for LDAC_W cycles.
- TICK: ldac_n high, sample_tick=1 for 1 cycle, then IDLE.
- run falling mid-update: the current update completes, including LDAC and TICK. No new starts occur.
- Reset (any time, asynchronous): cs_n all 1, sclk 0, sdi 0, ldac_n 1, sample_tick 0, busy 0, overrun_cnt 0, period counter 0, FSM IDLE.

## Timing
- Start at cycle S (LOAD). busy is high from S+1 through S+T.
- Per channel k (0-based), base B = S+1+34*CLK_DIV*k:
  - cs_n low for cycles B .. B+33*CLK_DIV-1.
  - Bit i (15..0) is valid on sdi from B+2*CLK_DIV*(15-i).
  - sclk rises at B+2*CLK_DIV*(15-i)+CLK_DIV.
- ldac_n low for cycles S+1+34*CLK_DIV*NUM_CH .. +LDAC_W-1.
- sample_tick fires at S+T, where T = 34*CLK_DIV*NUM_CH + LDAC_W + 1.
- Defaults: T = 275. Minimum overrun-free period = T+1 = 276.
- Only one cs_n bit is low at any time. ldac_n is never low while any cs_n is low.

## Test plan
- Defaults, run=1, period=1000, ch0=0xABC buf0 gain1x shdn_n1, ch1=0x123 buf1 gain2x shdn_n1.
  - SDI words: 0x3ABC on cs_n[0], then 0xD123 on cs_n[0].
  - ldac_n low at S+273..S+274, sample_tick at S+275; next start at S+1000.
- Defaults, period=200, run for 2000 cycles: starts only at multiples of 400 from the first start; overrun_cnt = 5 at cycle 2000.
- DATA_W=8, NUM_CH=4, ch2=0xA5 buf0 gain1x shdn_n1: 0x3A50 sent on cs_n[1] while cs_n[0]=1; 4 frames before ldac_n falls.
- Change ch_data at S+10: the transmitted frame still carries the LOAD-cycle value.
- Drop run at S+50: the update completes with tick at S+275 and no further starts. period=0 with run=1: starts are back-to-back, S' = S+276.
- Assert reset_n=0 mid-SHIFT (S+60): all outputs return to reset values in the same cycle; after release, the first start occurs on the first cycle with run=1.
